// File: rtl/lcd_pixel_fetch.sv
// RGB565 pixel fetch FIFO feeding the LCD timing driver, frame-aligned.
// Optional stats counters: define LCD_PIXEL_FETCH_STATS_EN.
module lcd_pixel_fetch #(
  parameter int          FIFO_AW        = 4,
  parameter int          PREFILL        = 8,
  parameter logic [15:0] UNDERRUN_COLOR = 16'hF800
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  output logic [15:0] pixel_data,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        frame_start,
`ifdef LCD_PIXEL_FETCH_STATS_EN
  output logic [15:0] underrun_cnt,
  output logic [15:0] frame_cnt,
`endif
  output logic        underrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PRE_L   = (FIFO_AW+1)'(PREFILL);

  typedef enum logic [1:0] {
    S_FLUSH, S_PREFILL, S_ARMED, S_STREAM
  } state_t;

  state_t               state_q, state_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [15:0]          pixel_data_q, pixel_data_d;
  logic                 src_ready_q, src_ready_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic [15:0]          mem_q [DEPTH];

  logic first_pix, last_pix, empty;
  logic serve, pop, push, ur_hit;

  always_comb begin
    first_pix = data_req && (pixel_xpos == 11'd0)
                && (pixel_ypos == 11'd1);
    last_pix  = data_req && (pixel_xpos == h_disp - 11'd1)
                && (pixel_ypos == v_disp);
    empty     = (level_q == '0);
    serve     = data_req && ((state_q == S_STREAM)
                || (first_pix && ((state_q == S_PREFILL)
                || (state_q == S_ARMED))));
    pop       = serve && !empty;
    ur_hit    = serve && empty;
    push      = src_valid && src_ready_q;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q | ur_hit;
    pixel_data_d  = 16'h0000;
    if (ur_hit)   pixel_data_d = UNDERRUN_COLOR;
    else if (pop) pixel_data_d = mem_q[rd_ptr_q];
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
    unique case (state_q)
      S_FLUSH: begin
        wr_ptr_d      = '0;
        rd_ptr_d      = '0;
        level_d       = '0;
        frame_start_d = 1'b1;
        underrun_d    = 1'b0;
        state_d       = S_PREFILL;
      end
      S_PREFILL: begin
        if (serve)                state_d = last_pix ? S_FLUSH : S_STREAM;
        else if (level_q >= PRE_L) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (serve) state_d = last_pix ? S_FLUSH : S_STREAM;
      end
      S_STREAM: begin
        if (serve && last_pix) state_d = S_FLUSH;
      end
      default: state_d = S_FLUSH;
    endcase
    // Held low for the frame_start cycle so no stale pre-restart word is taken.
    src_ready_d = (state_q != S_FLUSH) && (state_d != S_FLUSH)
                  && (level_d != DEPTH_L);
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q       <= S_FLUSH;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pixel_data_q  <= 16'h0000;
      src_ready_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pixel_data_q  <= pixel_data_d;
      src_ready_q   <= src_ready_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (push) mem_q[wr_ptr_q] <= src_data;
  end

  assign pixel_data  = pixel_data_q;
  assign src_ready   = src_ready_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

`ifdef LCD_PIXEL_FETCH_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    if (ur_hit && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    if (state_q == S_FLUSH)
      frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      underrun_cnt_q <= 16'h0000;
      frame_cnt_q    <= 16'h0000;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
  assign frame_cnt    = frame_cnt_q;
`endif

endmodule
